// File: rtl/mul16_sync_bridge_pkg.sv
// Shared types for the clocked bridge to the Balsa 16-bit Booth multiplier:
// data width, pull-channel and push-channel state encodings, and the
// next-state rule shared by the x and y operand channels.
package mul16_bridge_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACKED = 2'd1,
    DONE  = 2'd2
  } ch_state_e;

  typedef enum logic {
    Z_IDLE  = 1'b0,
    Z_ACKED = 1'b1
  } z_state_e;

  // Operand pull channel: ack only once the operand has settled (rdy), then
  // park in DONE until both channels have finished so the pair retires together.
  function automatic ch_state_e ch_next(input ch_state_e st, input logic r_s,
                                        input logic rdy, input logic retire);
    ch_state_e nxt;
    nxt = st;
    case (st)
      IDLE:    if (r_s && rdy) nxt = ACKED;
      ACKED:   if (!r_s) nxt = DONE;
      DONE:    if (retire) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mul16_sync_bridge_if.sv
// Clocked operand/result streams between synchronous logic and the bridge.
interface mul16_sync_bridge_if;
  import mul16_bridge_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_z;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_z
  );

endinterface

// File: rtl/mul16_sync_bridge_hs_sync.sv
// Multi-flop synchroniser for a single asynchronous handshake line.
module hs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw line one stage per clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Chain of flops; cleared on reset so no stale request survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mul16_sync_bridge.sv
// Bridge from valid/ready operand and result streams to the four-phase
// pull channels x/y and push channel z of the asynchronous multiplier.
module mul16_sync_bridge
  import mul16_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul16_sync_bridge_if.slave s_if,
  output logic              activate_0r,
  input  logic              activate_0a,
  input  logic              x_0r,
  output logic              x_0a,
  output logic [DATA_W-1:0] x_0d,
  input  logic              y_0r,
  output logic              y_0a,
  output logic [DATA_W-1:0] y_0d,
  input  logic              z_0r,
  output logic              z_0a,
  input  logic [DATA_W-1:0] z_0d,
  output logic [15:0]       pair_count,
  output logic              mul_done
);

  logic act_s, xr_s, yr_s, zr_s;
  logic [1:0] chr_s;

  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_act (.clk(clk), .rst(rst), .d(activate_0a), .q(act_s));
  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_x   (.clk(clk), .rst(rst), .d(x_0r),        .q(xr_s));
  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_y   (.clk(clk), .rst(rst), .d(y_0r),        .q(yr_s));
  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_z   (.clk(clk), .rst(rst), .d(z_0r),        .q(zr_s));

  assign chr_s = {yr_s, xr_s};

  // Operand register, its settle delay, and control/status flops.
  logic                   op_full_q, op_full_d;
  logic [DATA_W-1:0]      op_x_q, op_x_d, op_y_q, op_y_d;
  logic [SYNC_STAGES-1:0] op_dly_q, op_dly_d;
  logic                   in_ready_q, in_ready_d;
  logic                   act_q, act_d;
  logic                   mul_done_q, mul_done_d;
  logic [15:0]            pair_count_q, pair_count_d;
  logic                   accept, op_rdy, retire;

  // Result side.
  z_state_e               z_state_q, z_state_d;
  logic                   z_ack_q, z_ack_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_z_q, out_z_d;

  assign accept = s_if.in_valid && in_ready_q;
  // Operand data must have been stable for SYNC_STAGES+1 cycles before an ack.
  assign op_rdy = op_dly_q[SYNC_STAGES-1];

  // x (index 0) and y (index 1) pull channels: identical FSMs.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    ch_state_e st_q, st_d;
    logic      ack_q, ack_d;

    // Next state from the shared channel rule; ack is high exactly in ACKED.
    always_comb begin
      st_d  = ch_next(st_q, chr_s[g], op_rdy, retire);
      ack_d = (st_d == ACKED);
    end

    // Channel state and registered ack.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= IDLE;
        ack_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        ack_q <= ack_d;
      end
    end
  end

  assign retire = (g_ch[0].st_q == DONE) && (g_ch[1].st_q == DONE);

  // Operand register fill/retire, ready flag, pair counter, activation.
  always_comb begin
    op_full_d    = op_full_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    pair_count_d = pair_count_q;
    if (retire) begin
      op_full_d    = 1'b0;
      pair_count_d = pair_count_q + 16'd1;
    end
    if (accept) begin
      op_full_d = 1'b1;
      op_x_d    = s_if.in_x;
      op_y_d    = s_if.in_y;
    end
    op_dly_d   = retire ? '0 : {op_dly_q[SYNC_STAGES-2:0], op_full_q};
    in_ready_d = !op_full_d;
    act_d      = 1'b1;
    mul_done_d = mul_done_q | act_s;
  end

  // Operand-side registers; all outputs clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_full_q    <= 1'b0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_dly_q     <= '0;
      in_ready_q   <= 1'b0;
      act_q        <= 1'b0;
      mul_done_q   <= 1'b0;
      pair_count_q <= '0;
    end else begin
      op_full_q    <= op_full_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      op_dly_q     <= op_dly_d;
      in_ready_q   <= in_ready_d;
      act_q        <= act_d;
      mul_done_q   <= mul_done_d;
      pair_count_q <= pair_count_d;
    end
  end

  // Push channel z: capture only into an empty result register (back-pressure).
  always_comb begin
    z_state_d   = z_state_q;
    z_ack_d     = z_ack_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    if (out_valid_q && s_if.out_ready) out_valid_d = 1'b0;
    case (z_state_q)
      Z_IDLE: begin
        if (zr_s && !out_valid_q) begin
          out_z_d     = z_0d;
          out_valid_d = 1'b1;
          z_ack_d     = 1'b1;
          z_state_d   = Z_ACKED;
        end
      end
      Z_ACKED: begin
        if (!zr_s) begin
          z_ack_d   = 1'b0;
          z_state_d = Z_IDLE;
        end
      end
      default: z_state_d = Z_IDLE;
    endcase
  end

  // Result-side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_state_q   <= Z_IDLE;
      z_ack_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
    end else begin
      z_state_q   <= z_state_d;
      z_ack_q     <= z_ack_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
    end
  end

  assign s_if.in_ready  = in_ready_q;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_z     = out_z_q;
  assign activate_0r    = act_q;
  assign x_0a           = g_ch[0].ack_q;
  assign y_0a           = g_ch[1].ack_q;
  assign x_0d           = op_x_q;
  assign y_0d           = op_y_q;
  assign z_0a           = z_ack_q;
  assign pair_count     = pair_count_q;
  assign mul_done       = mul_done_q;

endmodule

// File: doc/mul16_sync_bridge.md
# mul16_sync_bridge

Clocked bridge between synchronous logic and the Balsa 16-bit Booth multiplier's four-phase channels. Upstream, it accepts operand pairs on a valid/ready stream and serves them to the multiplier's pull channels x and y. Downstream, it accepts products from the multiplier's push channel z and presents them on a valid/ready result stream. It lets clocked test harnesses and SoC logic drive the asynchronous multiplier directly.

## Interface
- SYNC_STAGES, 2, flops in each synchroniser on incoming request/ack lines (≥2)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand register empty
- in_x, in_y  in  16  operands
- out_valid  out  1  result register full
- out_ready  in  1  consumer accepts result
- out_z  out  16  product, low 16 bits
- activate_0r  out  1  multiplier activation request
- activate_0a  in  1  multiplier activation ack
- x_0r / y_0r  in  1  multiplier pulls an operand
- x_0a / y_0a  out  1  operand acks
- x_0d / y_0d  out  16  operand data
- z_0r  in  1  multiplier pushes a product
- z_0a  out  1  product ack
- z_0d  in  16  product data (bundled with z_0r)
- pair_count  out  16  retired operand pairs, wraps 65535→0
- mul_done  out  1  sticky; set when synced activate_0a is seen high

## Operation
- Reset values: every output is 0. This includes activate_0r, in_ready, x_0d, y_0d, out_z and pair_count.
- activate_0r rises on the first clk edge after rst deasserts and stays high until the next reset.
- Operand register:
  - Accept when in_valid && in_ready. in_ready = !op_full.
  - x_0d and y_0d are driven from the register at all times.
- x and y channels each run an independent state machine:
  - IDLE: ack = 0. On synced r = 1 and op_full → ACKED, ack = 1. If op_full = 0, remain in IDLE (stall).
  - ACKED: on synced r = 0 → DONE, ack = 0.
  - DONE: wait for pair retire.
  - A new r while in DONE is not acked.
- Retire happens when both channels are in DONE:
  - Both channels → IDLE.
  - op_full cleared.
  - pair_count incremented.
- z channel:
  - Z_IDLE: on synced z_0r = 1 and !out_valid, capture z_0d into out_z, set out_valid, set z_0a = 1, and go to Z_ACKED. If out_valid = 1, do not ack (back-pressure).
  - Z_ACKED: on synced z_0r = 0, set z_0a = 0 and go to Z_IDLE.
- out_valid clears on out_valid && out_ready.
- Capture requires out_valid = 0 at the start of the cycle. There is no same-cycle pop-and-refill.
- Arithmetic: none. out_z is the multiplier's 16-bit result unchanged.

## Timing
- Each incoming r/a line passes through SYNC_STAGES flops, followed by one state register.
- r edge at cycle t → ack change at cycle t+SYNC_STAGES+1.
- Data setup: x_0d/y_0d are stable for at least SYNC_STAGES+1 cycles before the ack rises. They change only after retire.
- z_0d is sampled on the same edge that raises z_0a. Bundling constraint: z_0d must be stable when z_0r reaches the synchroniser input.
- Operand throughput: at most one pair per full x/y four-phase cycle. A freed register is visible via in_ready one cycle after retire (no bypass).
- Simultaneous events:
  - Retire and in_valid in the same cycle: the new pair is accepted next cycle.
  - Pop and z_0r: z is captured the cycle after the pop.
- rst asserted at any time, including mid-handshake: all outputs go to 0 immediately and all state machines go to IDLE. The multiplier must be reset with it.

## Structure
- Package mul16_bridge_pkg holds:
  - DATA_W = 16.
  - Channel-state enum {IDLE, ACKED, DONE}.
  - Z-state enum {Z_IDLE, Z_ACKED}.
- Sub-module hs_sync (SYNC_STAGES-deep flop chain with asynchronous reset to 0), instantiated four times: activate_0a, x_0r, y_0r, z_0r.
- The x and y state machines are two instances of identical logic, written as a generate or a function.

## Test plan
- Reset release → all outputs 0 during reset; activate_0r = 1 one cycle after rst falls; pair_count = 0.
- Push (10000, 3), with a behavioural four-phase multiplier model responding → x_0d = 10000 at x_0a rise, y_0d = 3 at y_0a rise; out_z = 30000, out_valid = 1, pair_count = 1.
- Push (3, 10000) then (300, 300) back-to-back → results 30000, then 24464 (90000 mod 65536); pair_count = 2.
- Raise x_0r with no operand loaded, hold 20 cycles → x_0a stays 0. Then push (7, 9) → x_0a rises SYNC_STAGES+1 cycles after the register fills (if x_0r was already synced), with x_0d = 7.
- out_ready = 0 after the first result; the model raises z_0r for a second result → z_0a stays 0 and out_z is held. Set out_ready = 1 → pop; the second product is captured and acked the following cycles.
- Assert rst while x_0a = 1 → x_0a, activate_0r, in_ready and out_valid all go to 0 asynchronously, without waiting for a clk edge.
